req_gnt_arbiter: RTL
====================

Name: req_gnt_arbiter

Overview:
Upstream stage that produces the req/gnt pair consumed by the start-to-grant protocol checker, with the contract cStart |-> req ##GNT_LAT gnt.
- Arbitrates N requesters round-robin on a start strobe.
- Drives an aggregate req in the start cycle.
- Issues a one-cycle grant exactly GNT_LAT clocks later, together with a one-hot and encoded winner.
- The checker instance binds to req/gnt with cStart tied to start.

Parameters:
N, 4, number of requesters (2..16).
GNT_LAT, 2, rising edges from the sampled start edge to the edge that samples gnt high (1..15).
IDW, $clog2(N), width of gnt_id.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
start  input  1  arbitration start strobe (cStart), sampled at posedge.
req_vec  input  N  per-requester request bits, level.
req  output  1  aggregate request to the checker.
gnt  output  1  one-cycle grant pulse.
gnt_vec  output  N  one-hot winner, valid while gnt=1, else 0.
gnt_id  output  IDW  encoded winner, valid while gnt=1, else 0.
busy  output  1  high while in WAIT or GRANT.

Behaviour:
- Reset (reset=0, async): state=IDLE, gnt=0, gnt_vec=0, gnt_id=0, busy=0, lat_cnt=0, rr_ptr=N-1 (so requester 0 has first priority), lat_vec=0.
- req (combinational):
  - IDLE: |req_vec.
  - WAIT/GRANT: 1.
  - This guarantees req=1 at the start edge whenever a grant follows.
- FSM states are IDLE, WAIT and GRANT.
- IDLE:
  - start && |req_vec at edge T0: latch lat_vec=req_vec, compute the winner, load lat_cnt=GNT_LAT-1.
  - Go to WAIT if GNT_LAT>1, else to GRANT.
  - start && req_vec==0: ignored, stay IDLE; no gnt is ever issued for it.
- WAIT:
  - lat_cnt decrements each edge.
  - On the edge where lat_cnt==1, go to GRANT.
- GRANT (one cycle):
  - gnt=1, gnt_vec=1<<winner, gnt_id=winner; all outputs are registered.
  - rr_ptr<=winner at exit.
  - Next state is always IDLE.
- Latency: with GNT_LAT=2, start sampled at T0 gives gnt=1 sampled at T0+2 and gnt=0 at T0+3.
- Round-robin: the winner is the first set bit of lat_vec scanning rr_ptr+1, rr_ptr+2, ... modulo N. The winner is decided from the vector latched at T0; req_vec changes after T0 do not affect it.
- start while busy: ignored, no queueing. If it is re-asserted in the GRANT cycle it is also ignored. A new transaction can start only from IDLE, so back-to-back transactions are spaced by GNT_LAT+1 cycles minimum.
- Reset mid-operation: returns immediately to the reset values. A pending grant is discarded and gnt never pulses.
- gnt_vec is always one-hot or zero; gnt==|gnt_vec at all times.

Optional Feature:
ARB_DROP_CNT_EN
- Defined:
  - Adds output drop_cnt [7:0].
  - It increments (saturating at 255) on every sampled start that is ignored, either because busy=1 or because req_vec==0 in IDLE.
  - Reset value is 0.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, GRANT} arb_state_t;
  - localparam ARB_MAX_N=16 and ARB_MAX_LAT=15.
  - function onehot(idx) returning the N-bit one-hot vector.
- Sub-module rr_pick is purely combinational.
  - Inputs: vec[N], ptr[IDW].
  - Outputs: idx[IDW], found.
  - It is instantiated once, fed with req_vec in IDLE.

Test Plan:
- Single requester: reset released, req_vec=4'b0001, start pulse at edge T0 -> req=1 at T0; gnt=1, gnt_vec=0001, gnt_id=0 sampled at T0+2; gnt=0 at T0+3; checker passes.
- Round-robin: req_vec=4'b1111, four starts spaced 3 cycles apart -> gnt_id sequence 0,1,2,3, then 0 on the fifth start.
- Empty start: req_vec=0, start pulse -> req=0, no gnt within 5 cycles; drop_cnt=1 when ARB_DROP_CNT_EN is defined.
- Busy start: req_vec=4'b0010, start at T0 and again at T0+1 -> exactly one gnt, at T0+2 with gnt_id=1; drop_cnt=1.
- Reset mid-operation: start at T0, reset=0 asynchronously between T0+1 and T0+2 -> gnt stays 0, busy=0 immediately; after release, the next grant goes to requester 0 first.
- Latency sweep: GNT_LAT=1 and GNT_LAT=5 builds, req_vec=4'b1000 -> gnt sampled high exactly at T0+1 and T0+5 respectively, gnt_id=3.

Source files
------------

// File: rtl/req_gnt_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the req/gnt round-robin arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE, WAIT, GRANT)
//   ARB_MAX_N   : largest supported requester count
//   ARB_MAX_LAT : largest supported start-to-grant latency
//   onehot()    : index -> one-hot vector (ARB_MAX_N wide; callers truncate to N)
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } arb_state_t;

    localparam int ARB_MAX_N   = 16;
    localparam int ARB_MAX_LAT = 15;

    function automatic logic [ARB_MAX_N-1:0] onehot(input int unsigned idx);
        logic [ARB_MAX_N-1:0] v;
        v = ARB_MAX_N'(1) << idx;
        return v;
    endfunction

endpackage : arb_pkg

// File: rtl/req_gnt_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Scans vec starting one position after
// ptr (wrapping modulo N) and reports the first set bit.
// Ports:
//   vec   [N]   : candidate request vector
//   ptr   [IDW] : last winner; the search starts at ptr+1
//   idx   [IDW] : selected index (0 when nothing is set)
//   found       : 1 when vec has any bit set
// -----------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   vec,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] idx,
    output logic           found
);

    always_comb begin : scan
        int             pos;
        logic [IDW-1:0] pos_idx;
        idx     = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        // Offsets 1..N visit every requester once, ending on ptr itself, so
        // the previous winner has lowest priority.
        for (int k = 1; k <= N; k++) begin
            pos     = (int'(ptr) + k) % N;
            pos_idx = IDW'(pos);
            if (!found && vec[pos_idx]) begin
                idx   = pos_idx;
                found = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/req_gnt_arbiter.sv
// -----------------------------------------------------------------------------
// req_gnt_arbiter
// Round-robin arbiter producing the req/gnt pair for a start-to-grant checker
// (cStart |-> req ##GNT_LAT gnt, with cStart tied to start).
// A start strobe in IDLE with any request pending latches the request vector,
// then exactly GNT_LAT clocks later a one-cycle registered grant is issued with
// the winner in one-hot (gnt_vec) and encoded (gnt_id) form.
//
// Parameters:
//   N       : number of requesters (2..16)
//   GNT_LAT : edges from the sampled start edge to the edge sampling gnt=1 (1..15)
//   IDW     : width of gnt_id
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   start     in   arbitration start strobe
//   req_vec   in   [N] per-requester request levels
//   req       out  aggregate request (|req_vec in IDLE, 1 while busy)
//   gnt       out  one-cycle grant pulse
//   gnt_vec   out  [N] one-hot winner while gnt=1, else 0
//   gnt_id    out  [IDW] encoded winner while gnt=1, else 0
//   busy      out  high in WAIT or GRANT
//   drop_cnt  out  [8] saturating count of ignored starts
//                  (present only when ARB_DROP_CNT_EN is defined)
// -----------------------------------------------------------------------------
module req_gnt_arbiter
    import arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int GNT_LAT = 2,
    parameter int IDW     = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   req_vec,
    output logic           req,
    output logic           gnt,
    output logic [N-1:0]   gnt_vec,
    output logic [IDW-1:0] gnt_id,
    output logic           busy
`ifdef ARB_DROP_CNT_EN
    ,
    output logic [7:0]     drop_cnt
`endif
);

    localparam logic [3:0] LAT_LOAD = 4'(GNT_LAT - 1);

    arb_state_t     state;
    arb_state_t     state_next;
    logic [3:0]     lat_cnt;
    logic [IDW-1:0] rr_ptr;
    logic [N-1:0]   lat_vec;
    logic [N-1:0]   pick_vec;
    logic [IDW-1:0] pick_idx;
    logic           pick_found;
    logic           accept;

    // While idle the picker looks at the live requests; once a transaction is
    // accepted it looks at the latched copy. rr_ptr does not move until the
    // grant cycle, so the pick stays stable for the whole transaction.
    assign pick_vec = (state == IDLE) ? req_vec : lat_vec;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .vec   (pick_vec),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign accept = (state == IDLE) && start && pick_found;
    assign busy   = (state == WAIT) || (state == GRANT);
    assign req    = (state == IDLE) ? (|req_vec) : 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (GNT_LAT > 1) ? WAIT : GRANT;
                end
            end
            WAIT: begin
                if (lat_cnt == 4'd1) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_cnt <= '0;
            lat_vec <= '0;
        end else begin
            if (accept) begin
                lat_cnt <= LAT_LOAD;
                lat_vec <= req_vec;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
        end
    end

    // Grant outputs are registered: they are loaded on the edge that enters
    // GRANT and cleared on the edge that leaves it, giving a clean one-cycle
    // pulse with gnt == |gnt_vec by construction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt     <= 1'b0;
            gnt_vec <= '0;
            gnt_id  <= '0;
        end else if (state_next == GRANT) begin
            gnt     <= 1'b1;
            gnt_vec <= N'(onehot(32'(pick_idx)));
            gnt_id  <= pick_idx;
        end else begin
            gnt     <= 1'b0;
            gnt_vec <= '0;
            gnt_id  <= '0;
        end
    end

    // rr_ptr starts at N-1 so requester 0 is first in line after reset. It
    // advances only when a grant actually completes; a transaction cut short
    // by reset leaves no trace.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= IDW'(N - 1);
        end else if (state == GRANT) begin
            rr_ptr <= gnt_id;
        end
    end

`ifdef ARB_DROP_CNT_EN
    logic start_ignored;

    // Any sampled start that is not accepted was dropped: either busy, or
    // idle with no requester asserting.
    assign start_ignored = start && !accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (start_ignored && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule : req_gnt_arbiter
